// File: rtl/io_bus_arbiter_pkg.sv
// Shared bus-arbiter definitions: FSM encodings and signal polarities agreed
// between the stage controllers, the debug port and the arbiter.
package io_bus_arbiter_pkg;

  typedef enum logic {
    ARB_STATE_IDLE  = 1'b0,
    ARB_STATE_OWNED = 1'b1
  } arb_state_e;

  localparam logic GRANT_ENABLE     = 1'b1;
  localparam logic GRANT_DISABLE    = 1'b0;
  localparam logic REQ_ENABLE       = 1'b1;
  localparam logic FREE_ENABLE      = 1'b1;
  localparam logic BUS_ERROR_ENABLE = 1'b1;

  localparam int OWNER_W = 2;
  localparam int TMO_W   = 8;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after start, wrapping.
// Zero latency; valid low when no request is set.
module rr_priority_pick #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] winner,
  output logic         valid
);

  logic [W-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = W'((int'(start) + i) % N);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin IO bus arbiter with owner release, ownership timeout and error pulse.
// Grant 1 cycle after request; requests are not latched and are ignored while owned.
module io_bus_arbiter
  import io_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_MASTERS-1:0] io_bus_req,
  input  logic [NUM_MASTERS-1:0] io_bus_free,
  output logic [NUM_MASTERS-1:0] bus_io_grant,
  output logic [OWNER_W-1:0]     bus_owner,
  output logic                   bus_busy,
  output logic [NUM_MASTERS-1:0] bus_error
);

  localparam logic [OWNER_W-1:0] LAST_IDX = OWNER_W'(NUM_MASTERS - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  arb_state_e             state, state_nxt;
  logic [NUM_MASTERS-1:0] grant, grant_nxt;
  logic [NUM_MASTERS-1:0] error, error_nxt;
  logic [OWNER_W-1:0]     owner, owner_nxt;
  logic [OWNER_W-1:0]     last_owner, last_owner_nxt;
  logic [TMO_W-1:0]       cnt, cnt_nxt;
  logic [NUM_MASTERS-1:0] req_active;
  logic [OWNER_W-1:0]     start_idx, pick_idx;
  logic                   pick_vld;
  logic                   owner_free;

  assign req_active = REQ_ENABLE ? io_bus_req : ~io_bus_req;
  assign start_idx  = (last_owner == LAST_IDX) ? '0 : last_owner + 1'b1;
  assign owner_free = (io_bus_free[owner] == FREE_ENABLE);

  rr_priority_pick #(
    .N(NUM_MASTERS),
    .W(OWNER_W)
  ) u_pick (
    .req   (req_active),
    .start (start_idx),
    .winner(pick_idx),
    .valid (pick_vld)
  );

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    cnt_nxt        = cnt;
    error_nxt      = '0;
    case (state)
      ARB_STATE_IDLE: begin
        if (pick_vld) begin
          state_nxt           = ARB_STATE_OWNED;
          grant_nxt           = {NUM_MASTERS{GRANT_DISABLE}};
          grant_nxt[pick_idx] = GRANT_ENABLE;
          owner_nxt           = pick_idx;
          cnt_nxt             = '0;
        end
      end
      ARB_STATE_OWNED: begin
        // A release on the timeout edge takes priority, so no error is raised.
        if (owner_free) begin
          state_nxt      = ARB_STATE_IDLE;
          grant_nxt      = {NUM_MASTERS{GRANT_DISABLE}};
          last_owner_nxt = owner;
        end else if (cnt == TMO_LAST) begin
          state_nxt         = ARB_STATE_IDLE;
          grant_nxt         = {NUM_MASTERS{GRANT_DISABLE}};
          last_owner_nxt    = owner;
          error_nxt[owner]  = BUS_ERROR_ENABLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = ARB_STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ARB_STATE_IDLE;
      grant      <= {NUM_MASTERS{GRANT_DISABLE}};
      error      <= '0;
      owner      <= '0;
      last_owner <= LAST_IDX;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      error      <= error_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      cnt        <= cnt_nxt;
    end
  end

  assign bus_io_grant = grant;
  assign bus_owner    = owner;
  assign bus_busy     = |grant;
  assign bus_error    = error;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scoreboard bench for io_bus_arbiter: stimulus queues expected output changes
// (value plus cycle), a negedge monitor compares every observed change.
module tb_io_bus_arbiter;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [2:0] req = 3'b000;
  logic [2:0] free = 3'b000;
  logic [2:0] grant;
  logic [1:0] owner;
  logic       busy;
  logic [2:0] err;

  io_bus_arbiter #(
    .NUM_MASTERS(3),
    .TIMEOUT_CYCLES(255)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .io_bus_req  (req),
    .io_bus_free (free),
    .bus_io_grant(grant),
    .bus_owner   (owner),
    .bus_busy    (busy),
    .bus_error   (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [2:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic [2:0] err;
  } snap_t;

  typedef struct {
    string name;
    snap_t s;
    int    at;
  } exp_t;

  exp_t  exp_q[$];
  snap_t exp_cur;
  snap_t prev;
  snap_t cur;
  int    checks = 0;
  int    failures = 0;
  bit    mon_en = 1'b0;
  bit    armed = 1'b0;

  assign cur = {grant, owner, busy, err};

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (!armed) begin
        prev  = cur;
        armed = 1'b1;
      end else if (cur != prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change got grant=%b owner=%0d busy=%b err=%b @%0d want no change",
                   cur.grant, cur.owner, cur.busy, cur.err, cyc);
        end else begin
          e = exp_q.pop_front();
          if (cur != e.s || cyc != e.at) begin
            failures++;
            $display("FAIL %s got grant=%b owner=%0d busy=%b err=%b @%0d want grant=%b owner=%0d busy=%b err=%b @%0d",
                     e.name, cur.grant, cur.owner, cur.busy, cur.err, cyc,
                     e.s.grant, e.s.owner, e.s.busy, e.s.err, e.at);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_snap(input string nm, input logic [2:0] g, input logic [1:0] o,
                             input logic b, input logic [2:0] e, input int at);
    snap_t s;
    exp_t  x;
    s = {g, o, b, e};
    if (s != exp_cur) begin
      x.name = nm;
      x.s    = s;
      x.at   = at;
      exp_q.push_back(x);
      exp_cur = s;
    end
  endtask

  task automatic grant_of(input string nm, input logic [2:0] g, input logic [1:0] o);
    expect_snap(nm, g, o, 1'b1, 3'b000, cyc + 1);
  endtask

  task automatic release_of(input string nm, input logic [1:0] o);
    expect_snap(nm, 3'b000, o, 1'b0, 3'b000, cyc + 1);
  endtask

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog got cycle=%0d want finish before cycle 10000", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] g;
    logic [1:0] o;

    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    checks++;
    if (cur !== 9'b0) begin
      failures++;
      $display("FAIL reset_state got grant=%b owner=%0d busy=%b err=%b want all zero",
               cur.grant, cur.owner, cur.busy, cur.err);
    end
    exp_cur = '0;
    mon_en  = 1'b1;
    tick();
    tick();

    // Single one-cycle request from master 1, released later.
    req = 3'b010;
    grant_of("single_grant", 3'b010, 2'd1);
    tick();
    req = 3'b000;
    repeat (4) tick();
    free = 3'b010;
    release_of("single_free", 2'd1);
    tick();
    free = 3'b000;
    tick();

    // Reset in IDLE restores master 0 priority; bus_owner returns to 0.
    resetn = 1'b0;
    expect_snap("idle_reset", 3'b000, 2'd0, 1'b0, 3'b000, cyc + 1);
    tick();
    resetn = 1'b1;
    tick();

    // Round-robin with all requests held, two owned cycles each.
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      o = 2'(k % 3);
      g = 3'b001 << o;
      grant_of($sformatf("rr_grant%0d", k), g, o);
      tick();
      tick();
      free = g;
      release_of($sformatf("rr_free%0d", k), o);
      tick();
      free = 3'b000;
      if (k == 3) req = 3'b000;
    end
    tick();

    // Free in IDLE and stray frees from non-owners change nothing.
    free = 3'b111;
    tick();
    free = 3'b000;
    tick();
    req = 3'b001;
    grant_of("stray_grant", 3'b001, 2'd0);
    tick();
    req = 3'b000;
    tick();
    free = 3'b100;
    tick();
    free = 3'b010;
    tick();
    free = 3'b000;
    repeat (2) tick();
    free = 3'b001;
    release_of("stray_release", 2'd0);
    tick();
    free = 3'b000;
    tick();

    // Master 2 never frees: error pulse 255 cycles after grant; requests ignored meanwhile.
    req = 3'b100;
    grant_of("tmo_grant", 3'b100, 2'd2);
    tick();
    req = 3'b000;
    expect_snap("tmo_error", 3'b000, 2'd2, 1'b0, 3'b100, cyc + 255);
    expect_snap("tmo_error_end", 3'b000, 2'd2, 1'b0, 3'b000, cyc + 256);
    repeat (10) tick();
    req = 3'b011;
    repeat (3) tick();
    req = 3'b000;
    repeat (243) tick();
    req = 3'b101;
    grant_of("post_tmo_grant", 3'b001, 2'd0);
    tick();
    req = 3'b000;
    tick();
    free = 3'b001;
    release_of("post_tmo_free", 2'd0);
    tick();
    free = 3'b000;
    tick();

    // Free lands on the exact timeout edge: release wins, no error.
    req = 3'b010;
    grant_of("coin_grant", 3'b010, 2'd1);
    tick();
    req = 3'b000;
    repeat (254) tick();
    free = 3'b010;
    release_of("coin_free", 2'd1);
    tick();
    free = 3'b000;
    tick();

    // Reset while master 1 owns the bus, then master 0 wins a 0/1 request.
    req = 3'b010;
    grant_of("rst_grant", 3'b010, 2'd1);
    tick();
    req = 3'b000;
    tick();
    tick();
    resetn = 1'b0;
    expect_snap("rst_drop", 3'b000, 2'd0, 1'b0, 3'b000, cyc + 1);
    tick();
    resetn = 1'b1;
    req = 3'b011;
    grant_of("rst_rr", 3'b001, 2'd0);
    tick();
    req = 3'b000;
    tick();
    free = 3'b001;
    release_of("rst_free", 2'd0);
    tick();
    free = 3'b000;
    repeat (3) tick();

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_events got %0d outstanding (next %s @%0d) want 0",
               exp_q.size(), exp_q[0].name, exp_q[0].at);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 3, number of bus masters (IF-stage controller, MEM-stage controller, debug port).
REQ-002 Parameter TIMEOUT_CYCLES, default 255, maximum cycles a master may own the bus without releasing it.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 resetn  input  1  synchronous, active-low reset.
REQ-005 io_bus_req  input  NUM_MASTERS  per-master request; one bit per master, may be a single-cycle pulse.
REQ-006 io_bus_free  input  NUM_MASTERS  per-master release pulse; only the current owner's bit is honoured.
REQ-007 bus_io_grant  output  NUM_MASTERS  one-hot grant, level, held while owned.
REQ-008 bus_owner  output  2  index of the current owner; valid only while bus_busy=1.
REQ-009 bus_busy  output  1  high while any grant is asserted.
REQ-010 bus_error  output  NUM_MASTERS  one-cycle pulse to the owner on timeout.

Function
REQ-011 The arbiter SHALL have two states: IDLE and OWNED.
REQ-012 In IDLE with any io_bus_req bit high at edge k, the arbiter SHALL register the winner, assert its grant bit, set bus_busy=1, and enter OWNED, all visible after edge k (1-cycle latency).
REQ-013 Winner selection SHALL be round-robin: search begins at (last_owner+1) mod NUM_MASTERS and wraps; last_owner resets to NUM_MASTERS-1, so master 0 has first priority after reset.
REQ-014 Requests SHALL NOT be latched: a req bit low in the IDLE cycle is not considered.
REQ-015 In OWNED, the grant SHALL remain stable; all io_bus_req bits, including the owner's, SHALL be ignored.
REQ-016 In OWNED, when io_bus_free[owner]=1 at edge k, the arbiter SHALL clear the grant and bus_busy after edge k, set last_owner=owner, and return to IDLE.
REQ-017 io_bus_free from a non-owner, or any io_bus_free in IDLE, SHALL be ignored.
REQ-018 A 1-cycle IDLE turnaround SHALL separate consecutive owners, so no two grants are ever simultaneously high and handoff is never back-to-back.
REQ-019 Timeout counter (8 bits) behaviour:
- cleared on entry to OWNED;
- incremented each OWNED cycle without a valid free;
- when it reaches TIMEOUT_CYCLES, the arbiter SHALL pulse bus_error[owner] for one cycle, clear the grant, update last_owner, and return to IDLE.
REQ-020 When a valid free and the timeout coincide on the same edge, free SHALL win and no bus_error SHALL be raised.
REQ-021 bus_owner SHALL hold its last value when not busy; bus_error SHALL be zero except for the single timeout pulse.

Reset
REQ-022 With resetn=0 at a clk edge, the arbiter SHALL set:
- state=IDLE;
- bus_io_grant=0, bus_busy=0, bus_error=0, bus_owner=0;
- timeout counter=0, last_owner=NUM_MASTERS-1.
REQ-023 A reset during OWNED SHALL drop the grant on that edge; no bus_error SHALL be generated.

Structure
REQ-024 The state encodings (ARB_STATE_IDLE, ARB_STATE_OWNED), GRANT_ENABLE/DISABLE, REQ_ENABLE, FREE_ENABLE and BUS_ERROR_ENABLE SHALL reside in the shared bus_arbiter header so that the stage controllers and the arbiter agree on polarity.
REQ-025 Round-robin selection SHALL be a combinational sub-module rr_priority_pick (inputs: request vector and start index; outputs: winner index and valid).

Verification
REQ-026 Single request: req=3'b010 for one cycle after reset -> grant=3'b010 next cycle, bus_owner=1, bus_busy=1; free[1] 5 cycles later -> grant=0 next cycle.
REQ-027 Round-robin fairness: req=3'b111 held; each owner frees after 2 cycles -> grant order 001, 010, 100, 001, each separated by exactly one idle cycle.
REQ-028 Stray free: owner=0, free=3'b100 pulsed -> grant stays 3'b001, no state change.
REQ-029 Timeout: owner=2 never frees, TIMEOUT_CYCLES=255 -> bus_error=3'b100 for one cycle 255 cycles after grant, then grant=0; the next request from master 0 is granted.
REQ-030 Free coinciding with timeout on the same edge -> grant cleared, bus_error stays 0.
REQ-031 Reset mid-ownership: owner=1, resetn=0 for one edge -> grant=0 and bus_error=0 after that edge; req=3'b011 afterwards -> master 0 granted.
